// File: rtl/glyph_blitter.sv
// ============================================================================
// Module   : glyph_blitter
// Purpose  : Fetches an 8x8 glyph row by row from the character ROM and
//            streams it out as per-pixel write requests with backpressure.
// Revision : 1.0
// ============================================================================
`default_nettype none

module glyph_blitter #(
    parameter int X_W     = 11,
    parameter int Y_W     = 10,
    parameter int COLOR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [5:0]         req_code,
    input  logic [X_W-1:0]     req_x,
    input  logic [Y_W-1:0]     req_y,
    input  logic [COLOR_W-1:0] req_fg,
    input  logic [COLOR_W-1:0] req_bg,
    input  logic               req_transparent,
    output logic [8:0]         rom_addr,
    input  logic [7:0]         rom_data,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [X_W-1:0]     wr_x,
    output logic [Y_W-1:0]     wr_y,
    output logic [COLOR_W-1:0] wr_color,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EMIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [5:0]         r_code;
    logic [X_W-1:0]     r_x0;
    logic [Y_W-1:0]     r_y0;
    logic [COLOR_W-1:0] r_fg;
    logic [COLOR_W-1:0] r_bg;
    logic               r_transparent;
    logic [2:0]         r_row;
    logic [2:0]         r_col;
    logic [7:0]         r_shift;
    logic [8:0]         r_rom_addr;
    logic               w_advance;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next_state = S_FETCH;
            S_FETCH: w_next_state = S_EMIT;
            S_EMIT:  if (w_advance && (r_col == 3'd7))
                         w_next_state = (r_row == 3'd7) ? S_DONE : S_FETCH;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        wr_valid  = (r_state == S_EMIT) && (r_shift[7] || !r_transparent);
        wr_x      = r_x0 + {{(X_W-3){1'b0}}, r_col};
        wr_y      = r_y0 + {{(Y_W-3){1'b0}}, r_row};
        wr_color  = r_shift[7] ? r_fg : r_bg;
        rom_addr  = r_rom_addr;
    end

    // A skipped transparent pixel advances regardless of wr_ready.
    assign w_advance = (r_state == S_EMIT) && (!wr_valid || wr_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_code        <= '0;
            r_x0          <= '0;
            r_y0          <= '0;
            r_fg          <= '0;
            r_bg          <= '0;
            r_transparent <= 1'b0;
            r_row         <= '0;
            r_col         <= '0;
            r_shift       <= '0;
            r_rom_addr    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_code        <= req_code;
                        r_x0          <= req_x;
                        r_y0          <= req_y;
                        r_fg          <= req_fg;
                        r_bg          <= req_bg;
                        r_transparent <= req_transparent;
                        r_row         <= '0;
                        r_col         <= '0;
                        r_rom_addr    <= {req_code, 3'd0};
                    end
                end
                S_FETCH: begin
                    r_shift <= rom_data;
                    r_col   <= '0;
                end
                S_EMIT: begin
                    if (w_advance) begin
                        r_shift <= {r_shift[6:0], 1'b0};
                        r_col   <= r_col + 3'd1;
                        // Address of the next row is prepared ahead of its FETCH cycle.
                        if ((r_col == 3'd7) && (r_row != 3'd7)) begin
                            r_row      <= r_row + 3'd1;
                            r_rom_addr <= {r_code, r_row + 3'd1};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_glyph_blitter.sv
// Testbench for glyph_blitter: a behavioural ROM plus a per-glyph expected write list.
`default_nettype none

module tb_glyph_blitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_code;
    logic [10:0] req_x;
    logic [9:0]  req_y;
    logic [7:0]  req_fg;
    logic [7:0]  req_bg;
    logic        req_transparent;
    logic [8:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [10:0] wr_x;
    logic [9:0]  wr_y;
    logic [7:0]  wr_color;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic [7:0]  c;
    } wr_t;

    always #5 clk = ~clk;

    glyph_blitter #(.X_W(11), .Y_W(10), .COLOR_W(8)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_code(req_code),
        .req_x(req_x), .req_y(req_y), .req_fg(req_fg), .req_bg(req_bg),
        .req_transparent(req_transparent),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
        .busy(busy), .done(done)
    );

    function automatic logic [7:0] rom_f(input logic [8:0] a);
        logic [7:0] h;
        case (a[8:3])
            6'h30: case (a[2:0])
                3'd0: return 8'h3C; 3'd1: return 8'h66; 3'd2: return 8'h6E;
                3'd3: return 8'h76; 3'd4: return 8'h66; 3'd5: return 8'h66;
                3'd6: return 8'h3C; default: return 8'h00;
            endcase
            6'h31: case (a[2:0])
                3'd0: return 8'h18; 3'd1: return 8'h38; 3'd6: return 8'h7E;
                3'd7: return 8'h00; default: return 8'h18;
            endcase
            6'h3F: return 8'h00;
            default: begin
                h = a[7:0] * 8'd37;
                return h ^ {7'd0, a[8]} ^ 8'h5A;
            end
        endcase
    endfunction

    assign rom_data = rom_f(rom_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic run_glyph(input logic [5:0] code, input logic [10:0] x, input logic [9:0] y,
                             input logic [7:0] fg, input logic [7:0] bg, input logic tr,
                             input int stall_at, input int stall_len,
                             input bit rnd_bp, input bit hold_valid);
        wr_t        exp_q[$];
        wr_t        e;
        logic [7:0] bits;
        int         cyc, nwr, nstall;
        bit         done_seen, prev_stall;
        for (int r = 0; r < 8; r++) begin
            bits = rom_f({code, 3'(r)});
            for (int c = 0; c < 8; c++) begin
                if (bits[7-c] || !tr) begin
                    e.x = x + 11'(c);
                    e.y = y + 10'(r);
                    e.c = bits[7-c] ? fg : bg;
                    exp_q.push_back(e);
                end
            end
        end
        @(negedge clk);
        check("ready_idle", {31'd0, req_ready}, 1);
        req_code = code; req_x = x; req_y = y; req_fg = fg; req_bg = bg;
        req_transparent = tr; req_valid = 1'b1; wr_ready = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_valid) req_valid = 1'b0;
        req_code = 6'($urandom); req_x = 11'($urandom); req_y = 10'($urandom);
        req_fg = 8'($urandom); req_bg = 8'($urandom); req_transparent = 1'($urandom);
        cyc = 1; nwr = 0; nstall = 0; done_seen = 0; prev_stall = 0;
        while (!done_seen && cyc < 400) begin
            @(negedge clk);
            if (rnd_bp) wr_ready = ($urandom_range(0, 3) != 0);
            else        wr_ready = !(nwr == stall_at && nstall < stall_len);
            check("busy", {31'd0, busy}, 1);
            if (prev_stall) check("stall_valid", {31'd0, wr_valid}, 1);
            if (stall_len == 0 && !rnd_bp && cyc <= 64 && ((cyc - 1) % 9) == 0)
                check("rom_addr", {23'd0, rom_addr}, {23'd0, code, 3'((cyc - 1) / 9)});
            prev_stall = 0;
            if (wr_valid) begin
                if (nwr < exp_q.size()) begin
                    check("wr_x", {21'd0, wr_x}, {21'd0, exp_q[nwr].x});
                    check("wr_y", {22'd0, wr_y}, {22'd0, exp_q[nwr].y});
                    check("wr_color", {24'd0, wr_color}, {24'd0, exp_q[nwr].c});
                end else begin
                    check("extra_write", 1, 0);
                end
                if (wr_ready) nwr++;
                else begin nstall++; prev_stall = 1; end
            end
            if (done) begin
                check("done_cycle", cyc, 73 + nstall);
                check("write_count", nwr, exp_q.size());
                done_seen = 1;
                req_valid = 1'b0;
            end
            @(posedge clk);
            cyc++;
        end
        if (!done_seen) check("timeout", 0, 1);
        @(negedge clk);
        check("done_pulse_len", {31'd0, done}, 0);
        check("ready_after", {31'd0, req_ready}, 1);
        check("busy_after", {31'd0, busy}, 0);
        wr_ready = 1'b1;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; wr_ready = 1'b1;
        req_code = '0; req_x = '0; req_y = '0; req_fg = '0; req_bg = '0; req_transparent = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 1);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_wr_valid", {31'd0, wr_valid}, 0);
        check("rst_rom_addr", {23'd0, rom_addr}, 0);
        check("rst_wr_x", {21'd0, wr_x}, 0);
        check("rst_wr_y", {22'd0, wr_y}, 0);
        check("rst_wr_color", {24'd0, wr_color}, 0);
        reset = 1'b0;

        run_glyph(6'h30, 11'd100, 10'd50, 8'hFF, 8'h00, 1'b0, -1, 0, 0, 0);
        run_glyph(6'h31, 11'd0, 10'd0, 8'hA5, 8'h11, 1'b1, -1, 0, 0, 0);
        run_glyph(6'h30, 11'd100, 10'd50, 8'hFF, 8'h00, 1'b0, 18, 5, 0, 0);
        run_glyph(6'h30, 11'd2046, 10'd1020, 8'h3C, 8'hC3, 1'b0, -1, 0, 0, 0);

        // Reset in the middle of row 4 emission.
        @(negedge clk);
        req_code = 6'h30; req_x = 11'd10; req_y = 10'd20; req_fg = 8'h77;
        req_bg = 8'h88; req_transparent = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (39) @(posedge clk);
        @(negedge clk);
        check("pre_rst_valid", {31'd0, wr_valid}, 1);
        check("pre_rst_y", {22'd0, wr_y}, 24);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", {31'd0, wr_valid}, 0);
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_ready", {31'd0, req_ready}, 1);
        check("mid_rst_done", {31'd0, done}, 0);
        repeat (3) begin
            @(negedge clk);
            check("no_done_after_rst", {31'd0, done}, 0);
        end
        run_glyph(6'h12, 11'd300, 10'd200, 8'h5A, 8'hA5, 1'b0, -1, 0, 0, 0);

        run_glyph(6'h3F, 11'd7, 10'd9, 8'hFF, 8'h00, 1'b1, -1, 0, 0, 1);

        for (int i = 0; i < 6; i++)
            run_glyph(6'($urandom), 11'($urandom), 10'($urandom), 8'($urandom), 8'($urandom),
                      1'($urandom), -1, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
